// File: rtl/mem_write_buffer.sv
// mem_write_buffer
// Posted-write buffer between the data cache and data memory. Cache block
// writes are absorbed into a small circular queue in one cycle and drained
// to memory in the background. Block reads are served from the youngest
// buffered copy of the address when one exists. Otherwise they are sent to
// memory ahead of any queued writes.
//
// Ports
//   CLK, RESET      clock; synchronous active-high reset
//   C_READ/C_WRITE  cache block read / write requests (held while stalled)
//   C_ADDRESS       cache block address
//   C_WRITEDATA     block to be written
//   C_READDATA      block returned to the cache (forwarded or from memory)
//   C_BUSYWAIT      combinational stall back to the cache
//   M_READ/M_WRITE  registered memory requests (never both high)
//   M_ADDRESS       registered memory block address
//   M_WRITEDATA     registered memory write block
//   M_READDATA      block returned by memory
//   M_BUSYWAIT      memory busy
module mem_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              C_READ,
    input  logic              C_WRITE,
    input  logic [ADDR_W-1:0] C_ADDRESS,
    input  logic [DATA_W-1:0] C_WRITEDATA,
    output logic [DATA_W-1:0] C_READDATA,
    output logic              C_BUSYWAIT,
    output logic              M_READ,
    output logic              M_WRITE,
    output logic [ADDR_W-1:0] M_ADDRESS,
    output logic [DATA_W-1:0] M_WRITEDATA,
    input  logic [DATA_W-1:0] M_READDATA,
    input  logic              M_BUSYWAIT
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MWRITE = 2'd1,
        MREAD  = 2'd2
    } state_t;

    logic [ADDR_W-1:0] addr_mem_r [DEPTH];
    logic [DATA_W-1:0] data_mem_r [DEPTH];
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;
    state_t            state_r;
    state_t            state_s;
    logic              read_done_r;
    logic [DATA_W-1:0] rdata_r;
    logic              m_read_r;
    logic              m_write_r;
    logic [ADDR_W-1:0] m_address_r;
    logic [DATA_W-1:0] m_writedata_r;

    logic              m_read_s;
    logic              m_write_s;
    logic [ADDR_W-1:0] m_address_s;
    logic [DATA_W-1:0] m_writedata_s;
    logic              pop_s;
    logic              rd_complete_s;
    logic [PTR_W-1:0]  next_head_s;

    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic              any_match_s;
    logic              match_s;
    logic [PTR_W-1:0]  idx_s;
    logic [DATA_W-1:0] fwd_data_s;
    logic              hit_s;
    logic              read_miss_s;

    assign full_s  = (count_r == CNT_W'(DEPTH));
    assign empty_s = (count_r == {CNT_W{1'b0}});
    // Fullness uses the current count only: a slot freed by this edge's pop
    // becomes usable on the following cycle.
    assign push_s  = C_WRITE && !full_s;

    // Associative search over valid entries, oldest to youngest, so the
    // youngest matching entry is the one left in fwd_data_s.
    always_comb begin
        any_match_s = 1'b0;
        match_s     = 1'b0;
        idx_s       = head_r;
        fwd_data_s  = {DATA_W{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            idx_s       = head_r + PTR_W'(k);
            match_s     = (CNT_W'(k) < count_r) && (addr_mem_r[idx_s] == C_ADDRESS);
            any_match_s = any_match_s | match_s;
            fwd_data_s  = match_s ? data_mem_r[idx_s] : fwd_data_s;
        end
    end

    // A simultaneous read and write is handled as a write only.
    assign hit_s       = C_READ && !C_WRITE && any_match_s;
    assign read_miss_s = C_READ && !C_WRITE && !any_match_s && !read_done_r;

    assign C_BUSYWAIT  = C_WRITE ? full_s : read_miss_s;
    assign C_READDATA  = hit_s ? fwd_data_s : rdata_r;

    assign M_READ      = m_read_r;
    assign M_WRITE     = m_write_r;
    assign M_ADDRESS   = m_address_r;
    assign M_WRITEDATA = m_writedata_r;

    // Next-state and next memory-request logic. Read misses take priority
    // over draining: no buffered entry holds the missed address, so going
    // first cannot return stale data.
    always_comb begin
        state_s       = state_r;
        m_read_s      = m_read_r;
        m_write_s     = m_write_r;
        m_address_s   = m_address_r;
        m_writedata_s = m_writedata_r;
        pop_s         = 1'b0;
        rd_complete_s = 1'b0;
        next_head_s   = head_r + PTR_W'(1);
        case (state_r)
            IDLE: begin
                if (read_miss_s) begin
                    state_s     = MREAD;
                    m_read_s    = 1'b1;
                    m_address_s = C_ADDRESS;
                end else if (!empty_s) begin
                    state_s       = MWRITE;
                    m_write_s     = 1'b1;
                    m_address_s   = addr_mem_r[head_r];
                    m_writedata_s = data_mem_r[head_r];
                end else begin
                    state_s = IDLE;
                end
            end
            MWRITE: begin
                if (m_write_r && !M_BUSYWAIT) begin
                    pop_s     = 1'b1;
                    m_write_s = 1'b0;
                    if (read_miss_s) begin
                        state_s     = MREAD;
                        m_read_s    = 1'b1;
                        m_address_s = C_ADDRESS;
                    end else if (count_r > CNT_W'(1)) begin
                        // Back-to-back issue of the entry behind the one just popped.
                        state_s       = MWRITE;
                        m_write_s     = 1'b1;
                        m_address_s   = addr_mem_r[next_head_s];
                        m_writedata_s = data_mem_r[next_head_s];
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = MWRITE;
                end
            end
            MREAD: begin
                if (m_read_r && !M_BUSYWAIT) begin
                    rd_complete_s = 1'b1;
                    m_read_s      = 1'b0;
                    state_s       = IDLE;
                end else begin
                    state_s = MREAD;
                end
            end
            default: begin
                state_s   = IDLE;
                m_read_s  = 1'b0;
                m_write_s = 1'b0;
            end
        endcase
    end

    // Control state, memory-side registers, pointers and occupancy.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r       <= IDLE;
            head_r        <= {PTR_W{1'b0}};
            tail_r        <= {PTR_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
            read_done_r   <= 1'b0;
            rdata_r       <= {DATA_W{1'b0}};
            m_read_r      <= 1'b0;
            m_write_r     <= 1'b0;
            m_address_r   <= {ADDR_W{1'b0}};
            m_writedata_r <= {DATA_W{1'b0}};
        end else begin
            state_r       <= state_s;
            m_read_r      <= m_read_s;
            m_write_r     <= m_write_s;
            m_address_r   <= m_address_s;
            m_writedata_r <= m_writedata_s;
            // read_done lives for exactly the cycle after a memory read returns.
            read_done_r   <= rd_complete_s;
            rdata_r       <= rd_complete_s ? M_READDATA : rdata_r;
            head_r        <= pop_s ? (head_r + PTR_W'(1)) : head_r;
            tail_r        <= push_s ? (tail_r + PTR_W'(1)) : tail_r;
            count_r       <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // Entry storage; validity is tracked by head/count, so no reset needed.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            addr_mem_r[tail_r] <= C_ADDRESS;
            data_mem_r[tail_r] <= C_WRITEDATA;
        end
    end

endmodule

// File: tb/tb_mem_write_buffer.sv
// Self-checking bench for mem_write_buffer. The memory model raises busywait
// with a request, holds it 5 cycles, then completes on the next edge. A
// shadow memory holds the latest value the cache wrote to each block. Every
// read must return that value, and at the end memory must equal the shadow.
module tb_mem_write_buffer;

    logic        CLK;
    logic        RESET;
    logic        C_READ;
    logic        C_WRITE;
    logic [5:0]  C_ADDRESS;
    logic [31:0] C_WRITEDATA;
    logic [31:0] C_READDATA;
    logic        C_BUSYWAIT;
    logic        M_READ;
    logic        M_WRITE;
    logic [5:0]  M_ADDRESS;
    logic [31:0] M_WRITEDATA;
    logic [31:0] M_READDATA;
    logic        M_BUSYWAIT;

    mem_write_buffer #(.DEPTH(4), .ADDR_W(6), .DATA_W(32)) dut (
        .CLK(CLK), .RESET(RESET), .C_READ(C_READ), .C_WRITE(C_WRITE),
        .C_ADDRESS(C_ADDRESS), .C_WRITEDATA(C_WRITEDATA),
        .C_READDATA(C_READDATA), .C_BUSYWAIT(C_BUSYWAIT),
        .M_READ(M_READ), .M_WRITE(M_WRITE), .M_ADDRESS(M_ADDRESS),
        .M_WRITEDATA(M_WRITEDATA), .M_READDATA(M_READDATA),
        .M_BUSYWAIT(M_BUSYWAIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        bit          rd;
        logic [5:0]  a;
        logic [31:0] d;
        int          c;
    } op_t;

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    op_t         oplog   [$];
    logic [37:0] exp_wr  [$];
    int          mcnt;
    int          cyc;
    bit          both_seen;
    bit          mem_init;
    int          total;
    int          bad;

    assign M_BUSYWAIT = (M_READ || M_WRITE) && (mcnt < 5);
    assign M_READDATA = mem[M_ADDRESS];

    // Memory model: 5 busy cycles per request, completion on the following edge.
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= $urandom;
            mem_init <= 1'b1;
        end
        if (M_READ === 1'b1 && M_WRITE === 1'b1) both_seen <= 1'b1;
        if (RESET) begin
            mcnt <= 0;
        end else if (M_READ === 1'b1 || M_WRITE === 1'b1) begin
            if (mcnt < 5) begin
                mcnt <= mcnt + 1;
            end else begin
                mcnt <= 0;
                if (M_WRITE === 1'b1) begin
                    mem[M_ADDRESS] <= M_WRITEDATA;
                    oplog.push_back('{1'b0, M_ADDRESS, M_WRITEDATA, cyc + 1});
                end else begin
                    oplog.push_back('{1'b1, M_ADDRESS, M_READDATA, cyc + 1});
                end
            end
        end else begin
            mcnt <= 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            C_READ  = 1'b0;
            C_WRITE = 1'b0;
            @(posedge CLK);
        end
    endtask

    task automatic do_write(input logic [5:0] a, input logic [31:0] d,
                            output bit stalled, output int waits);
        stalled = 1'b0;
        waits   = 0;
        @(negedge CLK);
        C_READ      = 1'b0;
        C_WRITE     = 1'b1;
        C_ADDRESS   = a;
        C_WRITEDATA = d;
        #1;
        while (C_BUSYWAIT !== 1'b0 && waits < 100) begin
            stalled = 1'b1;
            waits++;
            @(negedge CLK);
            #1;
        end
        chk($sformatf("write_accept_%0h", a), 64'(C_BUSYWAIT), 64'(0));
        @(posedge CLK);
        ref_mem[a] = d;
        exp_wr.push_back({a, d});
    endtask

    task automatic do_read(input logic [5:0] a, output logic [31:0] data,
                           output int lowcyc, output int waits);
        waits = 0;
        @(negedge CLK);
        C_WRITE   = 1'b0;
        C_READ    = 1'b1;
        C_ADDRESS = a;
        #1;
        while (C_BUSYWAIT !== 1'b0 && waits < 200) begin
            waits++;
            @(negedge CLK);
            #1;
        end
        chk($sformatf("read_accept_%0h", a), 64'(C_BUSYWAIT), 64'(0));
        data   = C_READDATA;
        lowcyc = cyc;
        chk($sformatf("read_data_%0h", a), 64'(data), 64'(ref_mem[a]));
        @(posedge CLK);
    endtask

    // Wait for the buffer to go quiet, then match completed memory writes
    // against the accepted-write order.
    task automatic drain_and_verify(output int nreads);
        int  quiet;
        int  n;
        op_t e;
        logic [37:0] x;
        quiet  = 0;
        n      = 0;
        nreads = 0;
        while (quiet < 3 && n < 300) begin
            idle(1);
            #1;
            n++;
            if (M_WRITE === 1'b0 && M_READ === 1'b0) quiet++;
            else quiet = 0;
        end
        chk("drain_quiet", 64'(quiet), 64'(3));
        while (oplog.size() > 0) begin
            e = oplog.pop_front();
            if (e.rd) begin
                nreads++;
            end else if (exp_wr.size() == 0) begin
                chk("unexpected_write", 64'(e.a), 64'hFFFF);
            end else begin
                x = exp_wr.pop_front();
                chk("write_order", 64'({e.a, e.d}), 64'(x));
            end
        end
        chk("writes_outstanding", 64'(exp_wr.size()), 64'(0));
    endtask

    initial begin
        bit          st;
        int          w;
        int          lc;
        int          nr;
        int          hi;
        int          n;
        int          r;
        int          mism;
        logic [31:0] d;
        logic [5:0]  a;

        total       = 0;
        bad         = 0;
        RESET       = 1'b1;
        C_READ      = 1'b0;
        C_WRITE     = 1'b0;
        C_ADDRESS   = 6'd0;
        C_WRITEDATA = 32'd0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("rst_m_write", 64'(M_WRITE), 64'(0));
        chk("rst_m_read", 64'(M_READ), 64'(0));
        chk("rst_m_address", 64'(M_ADDRESS), 64'(0));
        chk("rst_m_writedata", 64'(M_WRITEDATA), 64'(0));
        chk("rst_c_readdata", 64'(C_READDATA), 64'(0));
        chk("rst_c_busywait", 64'(C_BUSYWAIT), 64'(0));
        ref_mem = mem;

        // Single write and its drain timing
        do_write(6'h05, 32'hDEADBEEF, st, w);
        chk("single_nostall", 64'(st), 64'(0));
        idle(1);
        @(negedge CLK);
        #1;
        chk("single_m_write", 64'(M_WRITE), 64'(1));
        chk("single_m_addr", 64'(M_ADDRESS), 64'(6'h05));
        chk("single_m_data", 64'(M_WRITEDATA), 64'(32'hDEADBEEF));
        hi = 0;
        while (M_WRITE === 1'b1 && hi < 20) begin
            hi++;
            @(negedge CLK);
            #1;
        end
        chk("single_high_cycles", 64'(hi), 64'(6));
        drain_and_verify(nr);

        // Full buffer: fifth write stalls until the first drain completes
        for (int i = 1; i <= 5; i++) begin
            do_write(6'(i), $urandom, st, w);
            if (i <= 4) begin
                chk($sformatf("full_nostall_%0d", i), 64'(st), 64'(0));
            end else begin
                chk("full_fifth_stalled", 64'(st), 64'(1));
                chk("full_accept_after_one", 64'(oplog.size()), 64'(1));
            end
        end
        drain_and_verify(nr);

        // Forwarding: youngest of two same-address writes, no memory read
        do_write(6'h0A, 32'h11111111, st, w);
        do_write(6'h0A, 32'h22222222, st, w);
        do_read(6'h0A, d, lc, w);
        chk("fwd_data", 64'(d), 64'(32'h22222222));
        chk("fwd_no_stall", 64'(w), 64'(0));
        drain_and_verify(nr);
        chk("fwd_no_mread", 64'(nr), 64'(0));

        // Read miss bypasses the queued write behind the one draining
        do_write(6'h01, $urandom, st, w);
        do_write(6'h02, $urandom, st, w);
        do_read(6'h30, d, lc, w);
        chk("bypass_log_size", 64'(oplog.size()), 64'(2));
        if (oplog.size() >= 2) begin
            chk("bypass_op0", 64'({oplog[0].rd, oplog[0].a}), 64'({1'b0, 6'h01}));
            chk("bypass_op1", 64'({oplog[1].rd, oplog[1].a}), 64'({1'b1, 6'h30}));
            chk("bypass_low_cycle", 64'(lc), 64'(oplog[1].c));
        end
        idle(12);
        chk("bypass_op2", 64'({oplog[2].rd, oplog[2].a}), 64'({1'b0, 6'h02}));
        drain_and_verify(nr);

        // Reset during a memory write discards buffered entries
        do_write(6'h21, $urandom, st, w);
        do_write(6'h22, $urandom, st, w);
        do_write(6'h23, $urandom, st, w);
        n = 0;
        #1;
        while (M_WRITE !== 1'b1 && n < 20) begin
            idle(1);
            #1;
            n++;
        end
        chk("mwrite_before_reset", 64'(M_WRITE), 64'(1));
        @(negedge CLK);
        RESET   = 1'b1;
        C_WRITE = 1'b0;
        C_READ  = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("mid_rst_m_write", 64'(M_WRITE), 64'(0));
        chk("mid_rst_m_read", 64'(M_READ), 64'(0));
        chk("mid_rst_c_readdata", 64'(C_READDATA), 64'(0));
        chk("mid_rst_c_busywait", 64'(C_BUSYWAIT), 64'(0));
        exp_wr.delete();
        ref_mem = mem;
        idle(10);
        #1;
        chk("mid_rst_no_drain", 64'(oplog.size()), 64'(0));
        chk("mid_rst_m_write_idle", 64'(M_WRITE), 64'(0));

        // Wrap-around: 10 writes with reads interleaved
        for (int i = 0; i < 10; i++) begin
            do_write(6'(6'h36 + i), $urandom, st, w);
            if (i % 2 == 1) do_read(6'(6'h36 + i - 1), d, lc, w);
        end
        drain_and_verify(nr);

        // Randomized mix of writes, hits, misses and idle gaps
        for (int it = 0; it < 40; it++) begin
            r = int'($urandom_range(0, 3));
            case (r)
                0, 1: begin
                    a = 6'(6'h10 + 6'($urandom_range(0, 7)));
                    do_write(a, $urandom, st, w);
                end
                2: begin
                    if ($urandom_range(0, 1) == 1) a = 6'(6'h10 + 6'($urandom_range(0, 7)));
                    else a = 6'(6'h20 + 6'($urandom_range(0, 7)));
                    do_read(a, d, lc, w);
                end
                default: idle(int'($urandom_range(0, 3)));
            endcase
        end
        drain_and_verify(nr);

        mism = 0;
        for (int i = 0; i < 64; i++) begin
            if (mem[i] !== ref_mem[i]) mism++;
        end
        chk("final_memory_image", 64'(mism), 64'(0));
        chk("never_read_and_write", 64'(both_seen), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
